// File: rtl/data_memory_if.sv
// Bus bundle for the MEM-stage data memory: write/read strobes, shared address,
// write data and combinational read data.
interface data_memory_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  memWrite;
  logic                  memRead;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] dataOut;

  modport master (
    output memWrite,
    output memRead,
    output addr,
    output dataIn,
    input  dataOut
  );

  modport slave (
    input  memWrite,
    input  memRead,
    input  addr,
    input  dataIn,
    output dataOut
  );
endinterface

// File: rtl/data_memory.sv
// Single-port data memory: synchronous write, combinational read, async clear.
// Optional macro READ_GATE_EN forces dataOut to zero unless memRead is 1.
module data_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  data_memory_if.slave        bus
);

  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  addr_ok;
  logic [IDX_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] read_word;

  // Address decode: anything at or beyond DEPTH is neither written nor read.
  always_comb begin
    addr_ok = 1'b0;
    idx     = bus.addr[IDX_WIDTH-1:0];
    if (int'(bus.addr) < DEPTH) begin
      addr_ok = 1'b1;
    end else begin
      addr_ok = 1'b0;
    end
  end

  // Storage: reset clears every word at once; a write needs memWrite to be exactly 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if ((bus.memWrite == 1'b1) && addr_ok) begin
      mem[idx] <= bus.dataIn;
    end
  end

  // Read path: no write-through bypass, so a same-cycle write shows only after the edge.
  always_comb begin
    read_word = {DATA_WIDTH{1'b0}};
`ifdef READ_GATE_EN
    if ((bus.memRead == 1'b1) && addr_ok) begin
      read_word = mem[idx];
    end else begin
      read_word = {DATA_WIDTH{1'b0}};
    end
`else
    if (addr_ok) begin
      read_word = mem[idx];
    end else begin
      read_word = {DATA_WIDTH{1'b0}};
    end
`endif
  end

`ifndef READ_GATE_EN
  logic unused_mem_read;
  assign unused_mem_read = bus.memRead;
`endif

  assign bus.dataOut = read_word;

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory plus hand-written reset,
// hold, collision and read-gate sequences.
module tb_data_memory;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // writes of i to address i, then readback with dataIn=FF and no write
    for (int i = 0; i < 8; i++) begin
      vecs[i]     = '{wr: 1'b1, a: 8'(i), d: 8'(i), exp: 8'(i)};
      vecs[i + 8] = '{wr: 1'b0, a: 8'(i), d: 8'hFF, exp: 8'(i)};
    end
    vecs[16] = '{wr: 1'b1, a: 8'hFF, d: 8'h5A, exp: 8'h5A};
    vecs[17] = '{wr: 1'b0, a: 8'hFE, d: 8'h77, exp: 8'h00};
    vecs[18] = '{wr: 1'b0, a: 8'hFF, d: 8'h00, exp: 8'h5A};
    vecs[19] = '{wr: 1'b1, a: 8'h10, d: 8'hC3, exp: 8'hC3};

    bus.memWrite = 1'b0;
    bus.memRead  = 1'b1;
    bus.addr     = 8'h00;
    bus.dataIn   = 8'h00;

    // 1. reset pulse with no clock edge, then sweep every address
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.addr = 8'(i);
      #0.1;
      check($sformatf("reset_sweep[%0d]", i), bus.dataOut, 8'h00);
    end

    // 2. table-driven writes and reads
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      bus.addr     = vecs[i].a;
      bus.dataIn   = vecs[i].d;
      bus.memWrite = vecs[i].wr;
      @(posedge clk); #1;
      bus.memWrite = 1'b0;
      check($sformatf("vec%0d", i), bus.dataOut, vecs[i].exp);
    end

    // second readback sweep: reads are non-destructive
    for (int i = 0; i < 8; i++) begin
      bus.addr = 8'(i);
      #1;
      check($sformatf("reread[%0d]", i), bus.dataOut, 8'(i));
    end

    // 3. hold: no write over four clocks
    bus.addr     = 8'h03;
    bus.dataIn   = 8'hFF;
    bus.memWrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold[%0d]", i), bus.dataOut, 8'h03);
    end

    // 6. read gate on addr 2
    bus.addr    = 8'h02;
    bus.memRead = 1'b0;
    #1;
`ifdef READ_GATE_EN
    check("gate_read0", bus.dataOut, 8'h00);
`else
    check("gate_read0", bus.dataOut, 8'h02);
`endif
    bus.memRead = 1'b1;
    #1;
    check("gate_read1", bus.dataOut, 8'h02);

    // 4. collision: old word before the edge, new word after
    @(posedge clk); #1;
    bus.addr     = 8'h05;
    bus.dataIn   = 8'hA5;
    bus.memWrite = 1'b1;
    #2;
    check("collide_before", bus.dataOut, 8'h05);
    @(posedge clk); #1;
    bus.memWrite = 1'b0;
    check("collide_after", bus.dataOut, 8'hA5);

    // 5. reset asserted during a pending write
    bus.addr     = 8'h80;
    bus.dataIn   = 8'h3C;
    bus.memWrite = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midwrite_during", bus.dataOut, 8'h00);
    bus.memWrite = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk); #1;
    check("midwrite_after", bus.dataOut, 8'h00);
    bus.addr = 8'h05;
    #1;
    check("cleared_addr5", bus.dataOut, 8'h00);
    bus.addr = 8'hFF;
    #1;
    check("cleared_addrFF", bus.dataOut, 8'h00);
    bus.addr = 8'h03;
    #1;
    check("cleared_addr3", bus.dataOut, 8'h00);

    // write works again after reset
    bus.addr     = 8'h80;
    bus.dataIn   = 8'h3C;
    bus.memWrite = 1'b1;
    @(posedge clk); #1;
    bus.memWrite = 1'b0;
    check("post_reset_write", bus.dataOut, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
